// File: rtl/cache_hier_pkg.sv
// Shared types and helpers for the two-level cache hierarchy controller.
// State and response-source encodings live here so bench and RTL agree on them.
package cache_hier_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      L1_RD  = 3'd1,
      L2_RD  = 3'd2,
      MEM_RD = 3'd3,
      FILL   = 3'd4,
      WRITE  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      SRC_L1  = 2'd0,
      SRC_L2  = 2'd1,
      SRC_MEM = 2'd2,
      SRC_WR  = 2'd3
   } src_t;

   // Longest of the three level latencies; sizes the shared latency counter.
   function automatic int max_delay(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/lat_counter.sv
// Per-state cycle counter: loads 1 on state entry and counts up, holding at all-ones.
// done flags the cycle in which the count equals the requested delay.
module lat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] delay,
   output logic [W-1:0] count,
   output logic         done
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (start) begin
         count <= W'(1);
      end else if (count != '1) begin
         count <= count + W'(1);
      end
   end

   assign done = (count == delay);

endmodule

// File: rtl/cache_hier_ctrl.sv
// Two-level cache hierarchy controller: valid/ready request in, one-cycle response out,
// read miss fill from L2/memory and write-through to every level.
module cache_hier_ctrl
   import cache_hier_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int L1_DELAY  = 3,
   parameter int L2_DELAY  = 3,
   parameter int MEM_DELAY = 8,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [1:0]        resp_src,
   output logic [ADDR_W-1:0] lvl_addr,
   output logic [DATA_W-1:0] lvl_wdata,
   output logic              l1_en,
   output logic              l2_en,
   output logic              mem_en,
   output logic              l1_we,
   output logic              l2_we,
   output logic              mem_we,
   input  logic              l1_hit,
   input  logic              l2_hit,
   input  logic [DATA_W-1:0] l1_rdata,
   input  logic [DATA_W-1:0] l2_rdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  cnt_l1_hit,
   output logic [CNT_W-1:0]  cnt_l2_hit,
   output logic [CNT_W-1:0]  cnt_mem
);

   localparam int MAX_D = max_delay(L1_DELAY, L2_DELAY, MEM_DELAY);
   localparam int LAT_W = $clog2(MAX_D + 1);

   // Handshake: a request transfers on an edge where req_valid && req_ready are both
   // high. req_ready is high only in IDLE and never while rst is asserted; the
   // requester holds req_valid (and its payload) until that edge.

   state_t              state_q, state_d;
   src_t                src_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [LAT_W-1:0]    lat_cnt;
   logic [LAT_W-1:0]    lat_delay;
   logic                lat_done;
   logic                lat_start;
   logic                accept;

   assign accept    = req_valid && req_ready;
   assign lat_start = (state_d != state_q);

   always_comb begin
      lat_delay = LAT_W'(L1_DELAY);
      unique case (state_q)
         L2_RD:   lat_delay = LAT_W'(L2_DELAY);
         MEM_RD:  lat_delay = LAT_W'(MEM_DELAY);
         WRITE:   lat_delay = LAT_W'(MAX_D);
         default: lat_delay = LAT_W'(L1_DELAY);
      endcase
   end

   lat_counter #(
      .W(LAT_W)
   ) u_lat (
      .clk   (clk),
      .rst   (rst),
      .start (lat_start),
      .delay (lat_delay),
      .count (lat_cnt),
      .done  (lat_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = req_we ? WRITE : L1_RD;
         end
         L1_RD: begin
            if (lat_done) state_d = l1_hit ? FILL : L2_RD;
         end
         L2_RD: begin
            if (lat_done) state_d = l2_hit ? FILL : MEM_RD;
         end
         MEM_RD: begin
            if (lat_done) state_d = FILL;
         end
         WRITE: begin
            if (lat_done) state_d = FILL;
         end
         FILL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic; FILL doubles as the write-done response cycle when src is SRC_WR.
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      l1_en      = 1'b0;
      l2_en      = 1'b0;
      mem_en     = 1'b0;
      l1_we      = 1'b0;
      l2_we      = 1'b0;
      mem_we     = 1'b0;
      unique case (state_q)
         IDLE:   req_ready = !rst;
         L1_RD:  l1_en     = 1'b1;
         L2_RD:  l2_en     = 1'b1;
         MEM_RD: mem_en    = 1'b1;
         FILL: begin
            resp_valid = 1'b1;
            if (src_q == SRC_L2 || src_q == SRC_MEM) begin
               l1_en = 1'b1;
               l1_we = 1'b1;
            end
            if (src_q == SRC_MEM) begin
               l2_en = 1'b1;
               l2_we = 1'b1;
            end
         end
         WRITE: begin
            l1_en  = (lat_cnt <= LAT_W'(L1_DELAY));
            l1_we  = (lat_cnt <= LAT_W'(L1_DELAY));
            l2_en  = (lat_cnt <= LAT_W'(L2_DELAY));
            l2_we  = (lat_cnt <= LAT_W'(L2_DELAY));
            mem_en = (lat_cnt <= LAT_W'(MEM_DELAY));
            mem_we = (lat_cnt <= LAT_W'(MEM_DELAY));
         end
         default: req_ready = 1'b0;
      endcase
   end

   // Captured request, fill data and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         src_q   <= SRC_L1;
      end else begin
         if (accept) begin
            addr_q <= req_addr;
            data_q <= req_wdata;
         end
         if (lat_done) begin
            unique case (state_q)
               L1_RD: begin
                  if (l1_hit) begin
                     data_q  <= l1_rdata;
                     rdata_q <= l1_rdata;
                     src_q   <= SRC_L1;
                  end
               end
               L2_RD: begin
                  if (l2_hit) begin
                     data_q  <= l2_rdata;
                     rdata_q <= l2_rdata;
                     src_q   <= SRC_L2;
                  end
               end
               MEM_RD: begin
                  data_q  <= mem_rdata;
                  rdata_q <= mem_rdata;
                  src_q   <= SRC_MEM;
               end
               WRITE:   src_q <= SRC_WR;
               default: src_q <= src_q;
            endcase
         end
      end
   end

   // Saturating performance counters, bumped in the response cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_l1_hit <= '0;
         cnt_l2_hit <= '0;
         cnt_mem    <= '0;
      end else if (state_q == FILL) begin
         if (src_q == SRC_L1 && cnt_l1_hit != '1) cnt_l1_hit <= cnt_l1_hit + CNT_W'(1);
         if (src_q == SRC_L2 && cnt_l2_hit != '1) cnt_l2_hit <= cnt_l2_hit + CNT_W'(1);
         if (src_q == SRC_MEM && cnt_mem != '1)   cnt_mem    <= cnt_mem + CNT_W'(1);
      end
   end

   assign lvl_addr   = addr_q;
   assign lvl_wdata  = data_q;
   assign resp_rdata = rdata_q;
   assign resp_src   = src_q;

endmodule

// File: tb/tb_cache_hier_ctrl.sv
// Directed bench for cache_hier_ctrl: reset, L1/L2/memory reads, write-through,
// mid-transaction reset and counter saturation with back-to-back requests.
module tb_cache_hier_ctrl;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 2;

   logic              clk;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic [1:0]        resp_src;
   logic [ADDR_W-1:0] lvl_addr;
   logic [DATA_W-1:0] lvl_wdata;
   logic              l1_en, l2_en, mem_en;
   logic              l1_we, l2_we, mem_we;
   logic              l1_hit, l2_hit;
   logic [DATA_W-1:0] l1_rdata, l2_rdata, mem_rdata;
   logic [CNT_W-1:0]  cnt_l1_hit, cnt_l2_hit, cnt_mem;

   cache_hier_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .L1_DELAY(3), .L2_DELAY(3),
      .MEM_DELAY(8), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_src(resp_src),
      .lvl_addr(lvl_addr), .lvl_wdata(lvl_wdata),
      .l1_en(l1_en), .l2_en(l2_en), .mem_en(mem_en),
      .l1_we(l1_we), .l2_we(l2_we), .mem_we(mem_we),
      .l1_hit(l1_hit), .l2_hit(l2_hit),
      .l1_rdata(l1_rdata), .l2_rdata(l2_rdata), .mem_rdata(mem_rdata),
      .cnt_l1_hit(cnt_l1_hit), .cnt_l2_hit(cnt_l2_hit), .cnt_mem(cnt_mem)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor state, sampled on the falling edge
   int acc_cnt, resp_cnt;
   int l1_en_n, l2_en_n, l1_we_n, l2_we_n, mem_we_n;
   int acc_e[$];
   int resp_e[$];
   logic [DATA_W-1:0] got_q[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [1:0]        snap_src;
   logic              snap_l1_we, snap_l2_we;
   logic [DATA_W-1:0] snap_wdata;
   logic [ADDR_W-1:0] snap_addr;

   always @(negedge clk) begin
      if (req_valid && req_ready) begin
         acc_cnt++;
         acc_e.push_back(edge_n);
      end
      if (l1_en)  l1_en_n++;
      if (l2_en)  l2_en_n++;
      if (l1_we)  l1_we_n++;
      if (l2_we)  l2_we_n++;
      if (mem_we) mem_we_n++;
      if (resp_valid) begin
         resp_cnt++;
         resp_e.push_back(edge_n);
         got_q.push_back(resp_rdata);
         snap_src   = resp_src;
         snap_l1_we = l1_we;
         snap_l2_we = l2_we;
         snap_wdata = lvl_wdata;
         snap_addr  = lvl_addr;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      acc_cnt = 0; resp_cnt = 0;
      l1_en_n = 0; l2_en_n = 0; l1_we_n = 0; l2_we_n = 0; mem_we_n = 0;
      acc_e.delete(); resp_e.delete(); got_q.delete();
   endtask

   // Driver: issue one request, wait (bounded) for its response; returns latency.
   task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, output int lat);
      int t;
      clear_stats();
      req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      t = 0;
      while (acc_cnt == 0 && t < 50) begin @(posedge clk); #1; t++; end
      req_valid = 1'b0;
      t = 0;
      while (resp_cnt == 0 && t < 100) begin @(posedge clk); #1; t++; end
      chk("resp_seen", resp_cnt, 1);
      lat = (acc_e.size() > 0 && resp_e.size() > 0) ? resp_e[0] - acc_e[0] : -1;
   endtask

   task automatic chk_data(input string tag);
      logic [DATA_W-1:0] g, e;
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk(tag, g, e);
   endtask

   initial begin
      int lat, t;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      l1_hit = 1'b0; l2_hit = 1'b0; l1_rdata = '0; l2_rdata = '0; mem_rdata = '0;
      clear_stats();

      // Reset state; a request during reset must not be taken
      repeat (3) @(posedge clk);
      #1 req_valid = 1'b1;
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_en", {l1_en, l2_en, mem_en, l1_we, l2_we, mem_we}, 0);
      chk("rst_cnt", {cnt_l1_hit, cnt_l2_hit, cnt_mem}, 0);
      chk("rst_rdata", resp_rdata, 0);
      @(posedge clk); #1;
      chk("rst_no_accept", acc_cnt, 0);
      req_valid = 1'b0; rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);
      @(posedge clk); #1;

      // L1 hit
      l1_hit = 1'b1; l1_rdata = 32'hDEADBEEF;
      exp_q.push_back(32'hDEADBEEF);
      run_txn(1'b0, 32'h40, 32'h0, lat);
      chk("l1_lat", lat, 4);
      chk_data("l1_rdata");
      chk("l1_src", snap_src, 0);
      chk("l1_cnt", cnt_l1_hit, 1);
      chk("l1_no_l2_en", l2_en_n, 0);
      chk("l1_en_cycles", l1_en_n, 3);
      chk("l1_addr", snap_addr, 32'h40);

      // L1 miss, L2 hit
      l1_hit = 1'b0; l2_hit = 1'b1; l2_rdata = 32'h12345678;
      exp_q.push_back(32'h12345678);
      run_txn(1'b0, 32'h80, 32'h0, lat);
      chk("l2_lat", lat, 7);
      chk_data("l2_rdata");
      chk("l2_src", snap_src, 1);
      chk("l2_fill_l1_we", snap_l1_we, 1);
      chk("l2_fill_no_l2_we", snap_l2_we, 0);
      chk("l2_fill_wdata", snap_wdata, 32'h12345678);
      chk("l2_l1_we_cycles", l1_we_n, 1);
      chk("l2_cnt", cnt_l2_hit, 1);

      // Miss in both levels
      l2_hit = 1'b0; mem_rdata = 32'hCAFEF00D;
      exp_q.push_back(32'hCAFEF00D);
      run_txn(1'b0, 32'hC0, 32'h0, lat);
      chk("mem_lat", lat, 15);
      chk_data("mem_rdata");
      chk("mem_src", snap_src, 2);
      chk("mem_fill_we", {snap_l1_we, snap_l2_we}, 2'b11);
      chk("mem_fill_wdata", snap_wdata, 32'hCAFEF00D);
      chk("mem_cnt", cnt_mem, 1);

      // Write-through; read data from the previous response must hold
      exp_q.push_back(32'hCAFEF00D);
      run_txn(1'b1, 32'h100, 32'hA5A5A5A5, lat);
      chk("wr_lat", lat, 9);
      chk_data("wr_rdata_held");
      chk("wr_src", snap_src, 3);
      chk("wr_l1_we_cycles", l1_we_n, 3);
      chk("wr_l2_we_cycles", l2_we_n, 3);
      chk("wr_mem_we_cycles", mem_we_n, 8);
      chk("wr_addr", snap_addr, 32'h100);
      chk("wr_wdata", snap_wdata, 32'hA5A5A5A5);
      chk("wr_cnts", {cnt_l1_hit, cnt_l2_hit, cnt_mem}, {2'd1, 2'd1, 2'd1});

      // Reset in the middle of a memory read
      clear_stats();
      req_we = 1'b0; req_addr = 32'hC0; req_valid = 1'b1;
      t = 0;
      while (acc_cnt == 0 && t < 50) begin @(posedge clk); #1; t++; end
      req_valid = 1'b0;
      chk("abort_accepted", acc_cnt, 1);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_en", {l1_en, l2_en, mem_en, l1_we, l2_we, mem_we}, 0);
      chk("abort_ready", req_ready, 1);
      repeat (20) @(posedge clk); #1;
      chk("abort_no_resp", resp_cnt, 0);
      chk("abort_cnts", {cnt_l1_hit, cnt_l2_hit, cnt_mem}, 0);
      chk("abort_rdata", resp_rdata, 0);

      // Five back-to-back L1 hits with req_valid held high; counter saturates at 3
      clear_stats();
      l1_hit = 1'b1; l1_rdata = 32'hDEADBEEF;
      req_we = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
      t = 0;
      while (resp_cnt < 5 && t < 200) begin @(posedge clk); #1; t++; end
      req_valid = 1'b0;
      repeat (4) @(posedge clk); #1;
      chk("b2b_accepts", acc_cnt, 5);
      chk("b2b_resps", resp_cnt, 5);
      chk("sat_cnt_l1", cnt_l1_hit, 3);
      if (acc_e.size() >= 5 && resp_e.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("b2b_lat%0d", i), resp_e[i] - acc_e[i], 4);
            exp_q.push_back(32'hDEADBEEF);
            chk_data($sformatf("b2b_rdata%0d", i));
         end
         for (int i = 1; i < 5; i++)
            chk($sformatf("b2b_gap%0d", i), acc_e[i] - resp_e[i-1], 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
